// File: rtl/iomem_line_master_pkg.sv
// iomem_line_master_pkg: FSM encoding, strobe constants,
// default geometry and the line-alignment helper.
package iomem_line_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [3:0] IOMEM_WSTRB_FULL = 4'hF;
  localparam logic [3:0] IOMEM_WSTRB_NONE = 4'h0;

  localparam int DEF_LINE_WORDS     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_W          = 11;

  // Clears the byte-within-line bits of an address.
  function automatic logic [31:0] line_align(
    input logic [31:0] addr,
    input int unsigned words
  );
    logic [31:0] mask;
    mask = (32'(words) << 2) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/iomem_beat_timer.sv
// iomem_beat_timer: per-beat wait counter; clr_i zeroes it,
// en_i counts, expire_o pulses on the last allowed cycle.
// Ports: clk_w, rst_n (sync, low), clr_i, en_i, expire_o.
module iomem_beat_timer
  import iomem_line_master_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk_w,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fires on the cycle the count sits at LIMIT-1 and
  // the beat is still waiting.
  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk_w) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iomem_line_master.sv
// iomem_line_master: splits one line request into LINE_WORDS
// single-word iomem beats, assembling reads / storing writes.
// Ports: clk_w, rst_n (sync, low); req_* line request in;
// resp_* completion out; iomem_* word-beat master port.
module iomem_line_master
  import iomem_line_master_pkg::*;
#(
  parameter int LINE_WORDS     = DEF_LINE_WORDS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                     clk_w,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic [31:0]              req_addr_i,
  input  logic [LINE_WORDS*32-1:0] req_wdata_i,
  output logic                     resp_valid_o,
  output logic                     resp_err_o,
  output logic [LINE_WORDS*32-1:0] resp_rdata_o,
  output logic                     iomem_valid_o,
  input  logic                     iomem_ready_i,
  output logic [3:0]               iomem_wstrb_o,
  output logic [31:0]              iomem_addr_o,
  output logic [31:0]              iomem_wdata_o,
  input  logic [31:0]              iomem_rdata_i
);

  localparam int BW = $clog2(LINE_WORDS);
  localparam int LB = LINE_WORDS * 32;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [31:0]   base_q, base_d;
  logic          write_q, write_d;
  logic [LB-1:0] line_q, line_d;
  logic          err_q, err_d;

  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [LB-1:0] rdata_q, rdata_d;
  logic          ivalid_q, ivalid_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_expire;
  logic [31:0]   req_base;

  assign req_base = line_align(req_addr_i, LINE_WORDS);
  assign tmr_en   = (state_q == ST_ISSUE) && !iomem_ready_i;

  iomem_beat_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_w    (clk_w),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    base_d       = base_q;
    write_d      = write_q;
    line_d       = line_q;
    err_d        = err_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    rdata_d      = rdata_q;
    ivalid_d     = ivalid_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tmr_clr      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Ready rises one cycle after the response pulse,
        // so no request overlaps a completion.
        req_ready_d = 1'b1;
        if (req_ready_q && req_valid_i) begin
          req_ready_d = 1'b0;
          write_d     = req_write_i;
          base_d      = req_base;
          line_d      = req_wdata_i;
          beat_d      = '0;
          tmr_clr     = 1'b1;
          ivalid_d    = 1'b1;
          addr_d      = req_base;
          wstrb_d     = req_write_i ? IOMEM_WSTRB_FULL
                                    : IOMEM_WSTRB_NONE;
          wdata_d     = req_write_i ? req_wdata_i[31:0] : 32'd0;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (iomem_ready_i) begin
          if (!write_q) begin
            rdata_d[{beat_q, 5'd0} +: 32] = iomem_rdata_i;
          end
          ivalid_d = 1'b0;
          state_d  = (beat_q == LAST_BEAT) ? ST_DONE : ST_GAP;
        end else if (tmr_expire) begin
          ivalid_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_GAP: begin
        // Base is line aligned, so OR-free add stays in line.
        beat_d   = beat_q + BW'(1);
        addr_d   = base_q + {{(30 - BW){1'b0}}, beat_d, 2'b00};
        wdata_d  = write_q ? line_q[{beat_d, 5'd0} +: 32] : 32'd0;
        tmr_clr  = 1'b1;
        ivalid_d = 1'b1;
        state_d  = ST_ISSUE;
      end

      ST_DONE: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        err_d        = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_w) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      base_q       <= '0;
      write_q      <= 1'b0;
      line_q       <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      ivalid_q     <= 1'b0;
      wstrb_q      <= IOMEM_WSTRB_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      write_q      <= write_d;
      line_q       <= line_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      ivalid_q     <= ivalid_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_err_o    = resp_err_q;
  assign resp_rdata_o  = rdata_q;
  assign iomem_valid_o = ivalid_q;
  assign iomem_wstrb_o = wstrb_q;
  assign iomem_addr_o  = addr_q;
  assign iomem_wdata_o = wdata_q;

endmodule

// File: tb/tb_iomem_line_master.sv
// tb_iomem_line_master: directed line requests against a
// latency-configurable iomem memory, checked by a cycle model.
module tb_iomem_line_master;

  localparam int LW = 4;
  localparam int TO = 1024;

  logic          clk_w = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_write_i = 1'b0;
  logic [31:0]   req_addr_i = '0;
  logic [127:0]  req_wdata_i = '0;
  logic          resp_valid_o;
  logic          resp_err_o;
  logic [127:0]  resp_rdata_o;
  logic          iomem_valid_o;
  logic          iomem_ready_i;
  logic [3:0]    iomem_wstrb_o;
  logic [31:0]   iomem_addr_o;
  logic [31:0]   iomem_wdata_o;
  logic [31:0]   iomem_rdata_i;

  always #5 clk_w = ~clk_w;

  iomem_line_master #(
    .LINE_WORDS     (LW),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (11)
  ) dut (
    .clk_w         (clk_w),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_write_i   (req_write_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .resp_valid_o  (resp_valid_o),
    .resp_err_o    (resp_err_o),
    .resp_rdata_o  (resp_rdata_o),
    .iomem_valid_o (iomem_valid_o),
    .iomem_ready_i (iomem_ready_i),
    .iomem_wstrb_o (iomem_wstrb_o),
    .iomem_addr_o  (iomem_addr_o),
    .iomem_wdata_o (iomem_wdata_o),
    .iomem_rdata_i (iomem_rdata_i)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Responder: ready after `lat` extra valid cycles, or never.
  logic [31:0] mem [0:255];
  int wait_cnt = 0;
  int lat = 0;
  bit never = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i >= 4 && i <= 7) return 32'h11 * 32'(i - 3);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  assign iomem_ready_i = iomem_valid_o && !never && (wait_cnt >= lat);
  assign iomem_rdata_i = mem[iomem_addr_o[9:2]];

  always @(posedge clk_w) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      wait_cnt <= 0;
    end else begin
      if (iomem_valid_o && iomem_ready_i && iomem_wstrb_o == 4'hF)
        mem[iomem_addr_o[9:2]] <= iomem_wdata_o;
      wait_cnt <= (iomem_valid_o && !iomem_ready_i) ? wait_cnt + 1 : 0;
    end
  end

  // Model: a request accepted in cycle A drives beat k during
  // cycles A+1+k*(L+2) .. +L, then one idle cycle; response
  // lands at A+1+LW*(L+2); a dead responder aborts after TO.
  int cyc = 0;
  bit outst = 1'b0;
  int acc_cyc = 0, m_lat = 0;
  logic [31:0] m_base = '0;
  bit m_wr = 1'b0;
  logic [127:0] m_wline = '0, m_rline = '0, exp_rdata = '0;
  int resp_cnt = 0, acc_cnt = 0, last_lat = 0, acc_gap = 0;
  int last_resp_cyc = -100, vhigh = 0;
  logic [31:0] first_addr = '0, last_addr = '0;
  logic last_err = 1'b0;

  always @(negedge clk_w) begin
    int t, p, k, r;
    bit ev, er;
    cyc++;
    ev = 1'b0; er = 1'b0; k = 0;
    if (outst) begin
      t = cyc - acc_cyc - 1;
      if (m_lat < 0) begin
        ev = (t < TO);
        er = (t == TO + 1);
      end else begin
        p  = m_lat + 2;
        k  = t / p;
        r  = t % p;
        ev = (k < LW) && (r <= m_lat);
        er = (t == LW * p);
      end
    end
    chk("req_ready", 128'(req_ready_o), 128'(!outst));
    chk("iomem_valid", 128'(iomem_valid_o), 128'(ev));
    if (ev) begin
      chk("iomem_addr", 128'(iomem_addr_o), 128'(m_base + 32'(4 * k)));
      chk("iomem_wstrb", 128'(iomem_wstrb_o), 128'(m_wr ? 4'hF : 4'h0));
      if (m_wr)
        chk("iomem_wdata", 128'(iomem_wdata_o), 128'(m_wline[32*k +: 32]));
      if (t == 0) first_addr = iomem_addr_o;
      last_addr = iomem_addr_o;
      vhigh++;
    end
    chk("resp_valid", 128'(resp_valid_o), 128'(er));
    if (er) begin
      if (!m_wr && m_lat >= 0) exp_rdata = m_rline;
      chk("resp_err", 128'(resp_err_o), 128'(m_lat < 0));
      chk("resp_rdata", resp_rdata_o, exp_rdata);
      outst = 1'b0;
      resp_cnt++;
      last_resp_cyc = cyc;
      last_lat = cyc - acc_cyc;
      last_err = resp_err_o;
    end else if (!outst) begin
      chk("rdata_hold", resp_rdata_o, exp_rdata);
    end
    if (!rst_n) begin
      outst = 1'b0;
      exp_rdata = '0;
    end else if (!outst && !er && req_valid_i) begin
      outst = 1'b1;
      acc_gap = cyc - last_resp_cyc;
      acc_cyc = cyc;
      acc_cnt++;
      m_wr = req_write_i;
      m_base = req_addr_i & ~32'(LW * 4 - 1);
      m_wline = req_wdata_i;
      m_lat = never ? -1 : lat;
      vhigh = 0;
      for (int j = 0; j < LW; j++)
        m_rline[32*j +: 32] = mem[m_base[9:2] + 8'(j)];
    end
  end

  task automatic send(input logic [31:0] a, input bit w,
                      input logic [127:0] d);
    int n;
    n = acc_cnt;
    @(posedge clk_w); #1;
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    for (int i = 0; i < 50 && acc_cnt == n; i++) begin
      @(posedge clk_w); #1;
    end
    req_valid_i = 1'b0;
    chk("accept", 128'(acc_cnt != n), 128'(1));
  endtask

  task automatic wait_resp(input int n0, input int budget);
    for (int i = 0; i < budget && resp_cnt <= n0; i++)
      @(posedge clk_w);
    #1;
    chk("resp_seen", 128'(resp_cnt > n0), 128'(1));
  endtask

  localparam logic [127:0] LINE_A =
    128'h00000044_00000033_00000022_00000011;

  initial begin
    int n0, a0;
    repeat (3) @(posedge clk_w);
    #1 rst_n = 1'b1;
    @(negedge clk_w);
    chk("rst_req_ready", 128'(req_ready_o), 128'(1));
    chk("rst_iomem_valid", 128'(iomem_valid_o), 128'(0));
    chk("rst_wstrb", 128'(iomem_wstrb_o), 128'(0));
    chk("rst_addr", 128'(iomem_addr_o), 128'(0));
    chk("rst_wdata", 128'(iomem_wdata_o), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid_o), 128'(0));
    chk("rst_rdata", resp_rdata_o, 128'(0));

    // 1: read, zero-wait
    lat = 0; never = 1'b0;
    n0 = resp_cnt;
    send(32'h4000_0010, 1'b0, '0);
    wait_resp(n0, 40);
    chk("t1_latency", 128'(last_lat), 128'(9));
    chk("t1_rdata", resp_rdata_o, LINE_A);
    chk("t1_err", 128'(last_err), 128'(0));

    // 2: write, 16-cycle responder
    lat = 16;
    n0 = resp_cnt;
    send(32'h4000_0100, 1'b1,
         {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    wait_resp(n0, 200);
    chk("t2_mem0", 128'(mem[64]), 128'(32'hA0));
    chk("t2_mem1", 128'(mem[65]), 128'(32'hA1));
    chk("t2_mem2", 128'(mem[66]), 128'(32'hA2));
    chk("t2_mem3", 128'(mem[67]), 128'(32'hA3));
    chk("t2_err", 128'(last_err), 128'(0));
    chk("t2_latency", 128'(last_lat), 128'(73));

    // 3: unaligned address
    lat = 0;
    n0 = resp_cnt;
    send(32'h4000_001B, 1'b0, '0);
    wait_resp(n0, 40);
    chk("t3_first_addr", 128'(first_addr), 128'(32'h4000_0010));
    chk("t3_last_addr", 128'(last_addr), 128'(32'h4000_001C));

    // 4: responder never ready
    never = 1'b1;
    n0 = resp_cnt;
    send(32'h4000_0020, 1'b0, '0);
    wait_resp(n0, 1100);
    chk("t4_valid_cycles", 128'(vhigh), 128'(1024));
    chk("t4_err", 128'(last_err), 128'(1));
    chk("t4_latency", 128'(last_lat), 128'(1026));
    @(negedge clk_w);
    chk("t4_ready_after", 128'(req_ready_o), 128'(1));
    never = 1'b0;

    // 5: reset during beat 2 of a read
    lat = 0;
    n0 = resp_cnt;
    send(32'h4000_0030, 1'b0, '0);
    repeat (4) @(posedge clk_w);
    #1 rst_n = 1'b0;
    @(negedge clk_w);
    chk("t5_beat2_valid", 128'(iomem_valid_o), 128'(1));
    chk("t5_beat2_addr", 128'(iomem_addr_o), 128'(32'h4000_0038));
    @(posedge clk_w);
    #1 rst_n = 1'b1;
    @(negedge clk_w);
    chk("t5_valid_dropped", 128'(iomem_valid_o), 128'(0));
    repeat (12) @(posedge clk_w);
    chk("t5_no_resp", 128'(resp_cnt), 128'(n0));
    n0 = resp_cnt;
    send(32'h4000_0010, 1'b0, '0);
    wait_resp(n0, 40);
    chk("t5_after_rdata", resp_rdata_o, LINE_A);

    // 6: back-to-back with req_valid held
    a0 = acc_cnt;
    n0 = resp_cnt;
    @(posedge clk_w); #1;
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h4000_0040;
    req_wdata_i = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    for (int i = 0; i < 60 && acc_cnt < a0 + 2; i++) begin
      @(posedge clk_w); #1;
    end
    req_valid_i = 1'b0;
    chk("t6_two_accepts", 128'(acc_cnt - a0), 128'(2));
    chk("t6_accept_gap", 128'(acc_gap), 128'(1));
    wait_resp(n0 + 1, 40);
    chk("t6_resp_count", 128'(resp_cnt - n0), 128'(2));
    chk("t6_mem0", 128'(mem[16]), 128'(32'hB0));
    chk("t6_mem3", 128'(mem[19]), 128'(32'hB3));

    repeat (3) @(posedge clk_w);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

endmodule
